// File: rtl/ram_pkg.sv
// Shared widths, defaults and FSM state type for the RAM memory controller.
package ram_pkg;

  localparam int unsigned ADDR_W      = 13;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned LATENCY_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Request captured from the cache in IDLE.
  typedef struct packed {
    logic              rnw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/ram_array.sv
// Single-port byte RAM: synchronous write, registered read, no reset.
module ram_array
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH = 8192,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and read ports share the address; read data only changes on re.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_mem_ctrl.sv
// Request/acknowledge controller in front of a byte RAM with fixed access latency.
module ram_mem_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEF,
  parameter int unsigned DEPTH   = 8192
) (
  input  logic              ram_clk,
  input  logic              areset,
  input  logic              avalid,
  input  logic              rnw,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rwdata,
  output logic              rack,
  output logic [DATA_W-1:0] rrdata,
  output logic              busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  req_t              req, req_next;
  logic              rd_valid, rd_valid_next;
  logic              mem_we, mem_re;
  logic [DATA_W-1:0] mem_q;

  // Next-state, capture and memory strobes; reset suppresses any access.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    req_next      = req;
    rd_valid_next = rd_valid;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    case (state)
      IDLE: begin
        if (avalid) begin
          req_next   = '{rnw: rnw, addr: raddr, wdata: rwdata};
          cnt_next   = CNT_W'(LATENCY - 1);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = ACK;
          mem_we     = ~req.rnw;
          mem_re     = req.rnw;
          if (req.rnw) begin
            rd_valid_next = 1'b1;
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      ACK: begin
        state_next = avalid ? HOLD : IDLE;
      end
      HOLD: begin
        if (!avalid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (areset) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  // Control state and registered status outputs.
  always_ff @(posedge ram_clk) begin
    if (areset) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_valid <= 1'b0;
      rack     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      rd_valid <= rd_valid_next;
      rack     <= (state_next == ACK);
      busy     <= (state_next != IDLE);
    end
  end

  // Captured request payload; a data path register, so no reset.
  always_ff @(posedge ram_clk) begin
    req <= req_next;
  end

  ram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (ram_clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (req.addr[AW-1:0]),
    .wdata (req.wdata),
    .rdata (mem_q)
  );

  // The array has no reset, so read data reads as zero until a read completes.
  assign rrdata = rd_valid ? mem_q : '0;

endmodule

// File: doc/ram_mem_ctrl.md
RAM_MEM_CTRL -- requirements
Module: ram_mem_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 4, request-capture-to-rack delay in ram_clk cycles (legal 1..15).
REQ-002 SHALL have parameter DEPTH, default 8192, number of byte locations (2**ADDR_W).
REQ-003 SHALL have port ram_clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port areset  input  1  reset, synchronous and active-high (sampled on ram_clk rising edge only).
REQ-005 SHALL have port avalid  input  1  request valid from cache; held high until rack seen.
REQ-006 SHALL have port rnw  input  1  1 = read, 0 = write; valid while avalid high.
REQ-007 SHALL have port raddr  input  13  byte address.
REQ-008 SHALL have port rwdata  input  8  write data.
REQ-009 SHALL have port rack  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rrdata  output  8  read data, valid in rack cycle, held until next read completes.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, ACK, HOLD.
REQ-013 IDLE: on edge with avalid=1, SHALL capture raddr/rnw/rwdata into registers, load counter with LATENCY-1, go WAIT; inputs ignored after capture.
REQ-014 WAIT: SHALL decrement counter each edge; at counter=0 go ACK; LATENCY=1 goes IDLE->WAIT->ACK with counter already 0.
REQ-015 ACK: rack SHALL be 1 for exactly this one cycle, first high after the LATENCY-th rising edge following the capture edge.
REQ-016 Write: memory location SHALL be updated on the edge entering ACK; read: rrdata SHALL be loaded from memory on the same edge.
REQ-017 ACK SHALL go to HOLD if avalid=1, else directly to IDLE.
REQ-018 HOLD: SHALL wait for avalid=0, then go IDLE; a new request needs avalid low for at least one sampled edge (no back-to-back re-capture of a stale request).
REQ-019 avalid dropped during WAIT (abort) SHALL NOT cancel the operation: write still performed, rack still pulsed.
REQ-020 rrdata SHALL be unchanged by writes and by rack of write operations.
REQ-021 Counter SHALL be 4 bits; no wrap beyond LATENCY-1.
REQ-022 Address SHALL be used modulo DEPTH; no out-of-range error.
REQ-023 Read-after-write to same address SHALL return the written byte.

Reset
REQ-024 areset=1 SHALL force state IDLE, counter 0, rack 0, busy 0, rrdata 8'h00 on the next edge, overriding all other activity.
REQ-025 Reset mid-WAIT SHALL discard the pending operation: no memory write, no rack.
REQ-026 Memory array contents SHALL NOT be cleared by reset.
REQ-027 avalid high during the reset edge SHALL NOT be captured; capture earliest on the first edge with areset=0.

Structure
REQ-028 Package ram_pkg SHALL hold ADDR_W=13, DATA_W=8, the FSM state enum and default LATENCY.
REQ-029 Memory SHALL be a sub-module ram_array: single-port, synchronous write, registered read, DEPTH x DATA_W, no reset.
REQ-030 Total RTL SHALL be 120-400 lines including ram_array.

Verification
REQ-031 Reset, then write 8'hA5 to 13'h0010, LATENCY=4 -> rack high 4 edges after capture for 1 cycle; busy high capture..ACK.
REQ-032 Read 13'h0010 after REQ-031 -> rrdata=8'hA5 in rack cycle, held after avalid drops.
REQ-033 Keep avalid high 3 cycles after rack -> state HOLD, no second rack; drop avalid one cycle, raise again -> new capture and rack.
REQ-034 Write 8'h3C to 13'h1FFF, drop avalid mid-WAIT -> rack still pulses; read 13'h1FFF returns 8'h3C.
REQ-035 Write 8'hFF to 13'h0020, assert areset 2 cycles into WAIT -> no rack, rrdata=8'h00; read 13'h0020 returns prior contents (not 8'hFF).
REQ-036 LATENCY=1 build: read request -> rack on first edge after capture; 1000 random read/write requests checked against a reference byte array, zero mismatches.
